ram_init_ctrl: RTL and testbench
================================

# ram_init_ctrl

Post-reset RAM initialisation sequencer for the SweRVolf external memory port. After reset release, it sweeps the whole RAM with AXI4 INCR write bursts, writing a fixed value or an address pattern. It then raises `o_init_done`, which drives the core's `i_ram_init_done` input. The block masters only the AW/W/B channels; the core's traffic is held off by the init-done gate.

## Interface
- `MEM_SIZE`, 32'h100000: bytes to initialise; must be a multiple of `BURST_LEN*8`.
- `BURST_LEN`, 16: beats per burst, range 1..256.
- `ID_WIDTH`, 6: AXI ID width.
- `INIT_VALUE`, 64'h0: fill data when the pattern mode is compiled out.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-high.
- `i_start` in 1: single-cycle re-initialisation request; honoured only in DONE.
- `o_busy` in/out: `o_busy` out 1: sweep in progress.
- `o_init_done` out 1: sweep complete.
- `o_init_error` out 1: sticky; at least one BRESP was non-OKAY.
- `o_awid` out ID_WIDTH; `o_awaddr` out 32; `o_awlen` out 8; `o_awsize` out 3; `o_awburst` out 2; `o_awvalid` out 1; `i_awready` in 1.
- `o_wdata` out 64; `o_wstrb` out 8; `o_wlast` out 1; `o_wvalid` out 1; `i_wready` in 1.
- `i_bid` in ID_WIDTH; `i_bresp` in 2; `i_bvalid` in 1; `o_bready` out 1.

## Operation
- FSM states: RST, BURST, RESP, DONE.
- RST → BURST on the first clock edge with `rst` low.
- **BURST:**
  - `o_awvalid` and `o_wvalid` are asserted together. Each is dropped independently once its handshake completes; AW and W complete in either order.
  - The state exits to RESP only when AW is accepted and the beat with `o_wlast` is accepted.
- **RESP:**
  - `o_bready`=1.
  - On `i_bvalid`: if `i_bresp`≠2'b00, set `o_init_error`. Then go to BURST for the next burst, or to DONE after the last burst.
  - `i_bid` is ignored.
- **DONE:**
  - `o_init_done`=1, `o_busy`=0.
  - `i_start`=1 clears `o_init_done` and `o_init_error`, resets the address to 0, and goes to BURST.
- **Constant AW fields:**
  - `o_awid`=0, `o_awlen`=BURST_LEN-1, `o_awsize`=3'd3, `o_awburst`=2'b01.
  - `o_awaddr` starts at 0 and steps by BURST_LEN*8; burst count = MEM_SIZE/(BURST_LEN*8).
- **W data:** `o_wstrb`=8'hFF. A beat counter (8 bits) counts 0..BURST_LEN-1, and `o_wlast` is asserted on beat BURST_LEN-1.
- **No overlap:** one burst is in flight at a time, and the next AW is never issued before the current B.
- **Address counter:** 32 bits, no wrap. The last burst's base address is MEM_SIZE-BURST_LEN*8.
- `o_busy`=1 in BURST and RESP.

## Timing
- **Reset values:** all valid outputs 0, `o_bready` 0, `o_busy` 0, `o_init_done` 0, `o_init_error` 0, `o_awaddr` 0, `o_wlast` 0.
- **Start:** the first `o_awvalid`/`o_wvalid` appear in the second rising edge after `rst` falls (cycle 1).
- **Stall behaviour:** while a valid is held and its ready is low, payload (address, data, `o_wlast`) is stable.
- **Burst duration:** with an always-ready slave returning `i_bvalid` the cycle after the last beat, each burst takes BURST_LEN+1 cycles.
- **Done:** `o_init_done` rises the cycle after the final B handshake.
- **Reset mid-sweep:** asynchronous `rst` at any time aborts the sweep, returns all outputs to reset values immediately, and restarts the sweep from address 0 after release. No partial-burst completion is attempted.
- **`i_start` corner cases:** `i_start` while busy is ignored. `i_start` in the same cycle as the final B handshake is ignored; DONE is still entered.
- **Error and early B:** a non-OKAY BRESP does not stop the sweep. `i_bvalid` outside RESP is not acknowledged.

## Configuration
- **`RAM_INIT_PATTERN_EN` defined:** each beat writes `{~addr, addr}`, where `addr` is that beat's 32-bit byte address. This lets software or a testbench detect address-decode faults.
- **Undefined:** every beat writes `INIT_VALUE`.

## Test plan
- **Default sweep timing:** `MEM_SIZE`=256, `BURST_LEN`=4, ideal slave → 8 bursts at awaddr 0x00,0x20..0xE0, awlen=3, 32 beats. `o_init_done` rises at cycle 41 after reset release; `o_init_error`=0.
- **Backpressure:** random `i_awready`/`i_wready`/`i_bvalid` stalls (0-5 cycles), including W completing before AW → memory contents identical to the ideal run. No beat is duplicated or dropped, and payload is stable under stall.
- **Error response:** SLVERR (2'b10) on burst 3 only → sweep continues to completion, `o_init_done`=1, `o_init_error`=1. A following `i_start` clears both, and a clean rerun ends with error 0.
- **Reset mid-sweep:** `rst` pulsed during burst 5, beat 2 → all outputs 0 within the reset cycle. After release the sweep restarts at awaddr 0 and completes normally.
- **Pattern mode:** with `RAM_INIT_PATTERN_EN`, the word at 0x48 reads 64'hFFFFFFB7_00000048. Without it, and with `INIT_VALUE`=64'hDEADBEEF_CAFEF00D, every word equals that value.
- **Ignored start:** `i_start` during BURST and in the same cycle as the final B → ignored, no restart, and `o_init_done` asserted once.

Source files
------------

// File: rtl/ram_init_ctrl.sv
// ram_init_ctrl: after reset, sweeps external RAM with AXI4 INCR write bursts, then raises o_init_done.
// Optional feature macro RAM_INIT_PATTERN_EN: each beat writes {~addr, addr} instead of INIT_VALUE.
module ram_init_ctrl #(
  parameter logic [31:0] MEM_SIZE   = 32'h100000,
  parameter int          BURST_LEN  = 16,
  parameter int          ID_WIDTH   = 6,
  parameter logic [63:0] INIT_VALUE = 64'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_init_done,
  output logic                o_init_error,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [ID_WIDTH-1:0] i_bid,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready
);

  typedef enum logic [1:0] {ST_RST, ST_BURST, ST_RESP, ST_DONE} state_t;

  localparam logic [7:0]  LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [31:0] STEP      = 32'(BURST_LEN * 8);
  localparam logic [31:0] LAST_ADDR = MEM_SIZE - STEP;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  beat_q, beat_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        err_q, err_d;
  logic        aw_fire, w_fire;
  logic        bid_unused;

  assign bid_unused = ^i_bid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RST;
      addr_q    <= '0;
      beat_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    o_awvalid = 1'b0;
    o_wvalid  = 1'b0;
    o_bready  = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    case (state_q)
      ST_RST: begin
        state_d   = ST_BURST;
        addr_d    = '0;
        beat_d    = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      ST_BURST: begin
        // AW and W retire independently; leave only once both halves of the burst are accepted.
        o_awvalid = !aw_done_q;
        o_wvalid  = !w_done_q;
        aw_fire   = o_awvalid && i_awready;
        w_fire    = o_wvalid && i_wready;
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire) begin
          if (beat_q == LAST_BEAT) w_done_d = 1'b1;
          else                     beat_d   = beat_q + 8'd1;
        end
        if (aw_done_d && w_done_d) begin
          state_d   = ST_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          beat_d    = '0;
        end
      end
      ST_RESP: begin
        o_bready = 1'b1;
        if (i_bvalid) begin
          if (i_bresp != 2'b00) err_d = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + STEP;
            state_d = ST_BURST;
          end
        end
      end
      ST_DONE: begin
        if (i_start) begin
          err_d   = 1'b0;
          addr_d  = '0;
          state_d = ST_BURST;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  assign o_busy       = (state_q == ST_BURST) || (state_q == ST_RESP);
  assign o_init_done  = (state_q == ST_DONE);
  assign o_init_error = err_q;
  assign o_awid       = '0;
  assign o_awaddr     = addr_q;
  assign o_awlen      = LAST_BEAT;
  assign o_awsize     = 3'd3;
  assign o_awburst    = 2'b01;
  assign o_wstrb      = 8'hFF;
  assign o_wlast      = o_wvalid && (beat_q == LAST_BEAT);

`ifdef RAM_INIT_PATTERN_EN
  logic [31:0] beat_addr;
  assign beat_addr = addr_q + {21'b0, beat_q, 3'b000};
  assign o_wdata   = {~beat_addr, beat_addr};
`else
  assign o_wdata = INIT_VALUE;
`endif

endmodule

// File: tb/tb_ram_init_ctrl.sv
// tb_ram_init_ctrl: randomized AXI write-slave bench for ram_init_ctrl with a word-level memory model.
module tb_ram_init_ctrl;

  localparam int          MEM  = 256;
  localparam int          BL   = 4;
  localparam int          IDW  = 6;
  localparam int          STEP = BL * 8;
  localparam int          NB   = MEM / STEP;
  localparam int          NW   = MEM / 8;
  localparam logic [63:0] INIT = 64'hDEADBEEF_CAFEF00D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic o_busy, o_init_done, o_init_error;
  logic [IDW-1:0] o_awid;
  logic [31:0] o_awaddr;
  logic [7:0] o_awlen;
  logic [2:0] o_awsize;
  logic [1:0] o_awburst;
  logic o_awvalid;
  logic i_awready = 1'b0;
  logic [63:0] o_wdata;
  logic [7:0] o_wstrb;
  logic o_wlast, o_wvalid;
  logic i_wready = 1'b0;
  logic [IDW-1:0] i_bid = '0;
  logic [1:0] i_bresp = 2'b00;
  logic i_bvalid = 1'b0;
  logic o_bready;

  ram_init_ctrl #(
    .MEM_SIZE(32'(MEM)), .BURST_LEN(BL), .ID_WIDTH(IDW), .INIT_VALUE(INIT)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .o_busy(o_busy), .o_init_done(o_init_done), .o_init_error(o_init_error),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready), .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid),
    .o_bready(o_bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Slave-side view of a sweep: memory image, per-word write counts, AW log, protocol tallies.
  logic [63:0] mem [NW];
  int          wcnt [NW];
  logic [31:0] aw_log [$];
  int  n_beats, bad_fields, bad_wlast, bad_stab, bad_overlap;
  int  done_cycle, first_valid_cycle;
  bit  timed_out, model_err, err_after_start;

  function automatic logic [63:0] exp_word(input logic [31:0] a);
`ifdef RAM_INIT_PATTERN_EN
    return {~a, a};
`else
    return INIT;
`endif
  endfunction

  function automatic int content_errors();
    int n = 0;
    for (int i = 0; i < NW; i++)
      if (wcnt[i] != 1 || mem[i] !== exp_word(32'(i * 8))) n++;
    return n;
  endfunction

  function automatic int aw_errors();
    int n = 0;
    if (aw_log.size() != NB) n++;
    for (int i = 0; i < aw_log.size() && i < NB; i++)
      if (aw_log[i] !== 32'(i * STEP)) n++;
    return n;
  endfunction

  task automatic idle_inputs();
    i_awready = 1'b0;
    i_wready  = 1'b0;
    i_bvalid  = 1'b0;
    i_bresp   = 2'b00;
    i_start   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
  endtask

  // Plays an AXI slave for one sweep, from reset release or an i_start pulse, until o_init_done.
  task automatic run_sweep(input bit stall, input int err_burst, input int abort_burst,
                           input bit via_start, input int start_at, input bit start_last);
    int cycle, aw_burst, w_burst, w_beat, b_done, b_wait;
    bit pending, committed, prev_awstall, prev_wstall, prev_last;
    logic [31:0] prev_addr, a;
    logic [63:0] prev_data;
    logic [63:0] wq [$];
    for (int i = 0; i < NW; i++) begin mem[i] = 'x; wcnt[i] = 0; end
    aw_log.delete();
    n_beats = 0; bad_fields = 0; bad_wlast = 0; bad_stab = 0; bad_overlap = 0;
    done_cycle = -1; first_valid_cycle = -1; timed_out = 0; model_err = 0; err_after_start = 1;
    cycle = 0; aw_burst = 0; w_burst = 0; w_beat = 0; b_done = 0; b_wait = 0;
    committed = 0; prev_awstall = 0; prev_wstall = 0; prev_last = 0;
    prev_addr = '0; prev_data = '0;
    @(negedge clk);
    idle_inputs();
    if (via_start) i_start = 1'b1;
    else           rst = 1'b0;
    while (1) begin
      @(posedge clk);
      #1;
      cycle++;
      i_start = 1'b0;
      if (cycle > 2000) begin timed_out = 1; idle_inputs(); break; end
      if (prev_awstall && (o_awvalid !== 1'b1 || o_awaddr !== prev_addr)) bad_stab++;
      if (prev_wstall && (o_wvalid !== 1'b1 || o_wdata !== prev_data || o_wlast !== prev_last)) bad_stab++;
      if (cycle == 1) err_after_start = o_init_error;
      if (o_init_done === 1'b1) begin done_cycle = cycle; idle_inputs(); break; end
      if (first_valid_cycle < 0 && (o_awvalid || o_wvalid)) first_valid_cycle = cycle;
      if (abort_burst >= 0 && w_burst == abort_burst && w_beat == 2 && o_wvalid) begin
        rst = 1'b1;
        break;
      end
      pending = (aw_burst > b_done) && (w_burst > b_done);
      if (pending && !committed) begin
        if (wq.size() != BL) bad_fields++;
        for (int k = 0; k < wq.size(); k++) begin
          a = aw_log[b_done] + 32'(8 * k);
          if ((a >> 3) < NW) begin mem[a >> 3] = wq[k]; wcnt[a >> 3]++; end
          else bad_fields++;
        end
        wq.delete();
        committed = 1;
        b_wait = stall ? int'($urandom_range(0, 5)) : 0;
      end
      i_awready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      i_wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stall && aw_burst == 2 && w_burst <= 2) i_awready = 1'b0;
      i_bid = IDW'($urandom);
      i_bvalid = 1'b0;
      i_bresp = 2'b00;
      if (pending) begin
        if (b_wait > 0) b_wait--;
        else begin
          i_bvalid = 1'b1;
          i_bresp = (b_done == err_burst) ? 2'b10 : 2'b00;
        end
      end else if (stall && $urandom_range(0, 3) == 0) begin
        i_bvalid = 1'b1;
      end
      if (cycle == start_at) i_start = 1'b1;
      if (start_last && pending && i_bvalid && b_done == NB - 1) i_start = 1'b1;
      if (o_awvalid && i_awready) begin
        if (o_awid !== '0 || o_awlen !== 8'(BL - 1) || o_awsize !== 3'd3 || o_awburst !== 2'b01)
          bad_fields++;
        if (aw_burst > b_done) bad_overlap++;
        aw_log.push_back(o_awaddr);
        aw_burst++;
      end
      if (o_wvalid && i_wready) begin
        if (w_burst > b_done) bad_overlap++;
        if (o_wstrb !== 8'hFF) bad_fields++;
        if (o_wlast !== (w_beat == BL - 1)) bad_wlast++;
        wq.push_back(o_wdata);
        n_beats++;
        if (w_beat == BL - 1) begin w_beat = 0; w_burst++; end
        else w_beat++;
      end
      if (o_bready && !pending) bad_overlap++;
      if (i_bvalid && o_bready && pending) begin
        if (i_bresp != 2'b00) model_err = 1;
        b_done++;
        committed = 0;
      end
      prev_awstall = o_awvalid && !i_awready;
      prev_addr    = o_awaddr;
      prev_wstall  = o_wvalid && !i_wready;
      prev_data    = o_wdata;
      prev_last    = o_wlast;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({o_awvalid, o_wvalid, o_bready, o_busy, o_init_done, o_init_error, o_wlast} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got %b expected 0000000",
               {o_awvalid, o_wvalid, o_bready, o_busy, o_init_done, o_init_error, o_wlast});
    end
    checks++;
    if (o_awaddr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_awaddr got %h expected 00000000", o_awaddr);
    end
  endtask

  task automatic test_default_sweep();
    do_reset();
    run_sweep(0, -1, -1, 0, -1, 0);
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("[TB] FAIL default_timeout got 1 expected 0"); end
    checks++;
    if (first_valid_cycle != 1) begin
      failures++; $display("[TB] FAIL default_first_valid got %0d expected 1", first_valid_cycle);
    end
    checks++;
    if (done_cycle != 41) begin failures++; $display("[TB] FAIL default_done_cycle got %0d expected 41", done_cycle); end
    checks++;
    if (aw_errors() != 0) begin failures++; $display("[TB] FAIL default_awaddr got %0d bad expected 0", aw_errors()); end
    checks++;
    if (n_beats != NB * BL) begin failures++; $display("[TB] FAIL default_beats got %0d expected %0d", n_beats, NB * BL); end
    checks++;
    if (content_errors() != 0) begin
      failures++; $display("[TB] FAIL default_contents got %0d bad words expected 0", content_errors());
    end
    checks++;
    if (bad_fields + bad_wlast + bad_overlap != 0) begin
      failures++;
      $display("[TB] FAIL default_protocol got fields=%0d wlast=%0d overlap=%0d expected 0",
               bad_fields, bad_wlast, bad_overlap);
    end
    checks++;
    if ({o_init_error, o_busy} !== 2'b00) begin
      failures++; $display("[TB] FAIL default_err_busy got %b expected 00", {o_init_error, o_busy});
    end
    checks++;
`ifdef RAM_INIT_PATTERN_EN
    if (mem[9] !== 64'hFFFFFFB7_00000048) begin
      failures++; $display("[TB] FAIL pattern_word_48 got %h expected FFFFFFB700000048", mem[9]);
    end
`else
    if (mem[9] !== 64'hDEADBEEF_CAFEF00D) begin
      failures++; $display("[TB] FAIL init_word_48 got %h expected DEADBEEFCAFEF00D", mem[9]);
    end
`endif
  endtask

  task automatic test_backpressure();
    do_reset();
    run_sweep(1, -1, -1, 0, -1, 0);
    checks++;
    if (timed_out !== 1'b0 || done_cycle < 0) begin
      failures++; $display("[TB] FAIL bp_completion got done_cycle=%0d expected completion", done_cycle);
    end
    checks++;
    if (content_errors() != 0) begin
      failures++; $display("[TB] FAIL bp_contents got %0d bad words expected 0", content_errors());
    end
    checks++;
    if (aw_errors() != 0) begin failures++; $display("[TB] FAIL bp_awaddr got %0d bad expected 0", aw_errors()); end
    checks++;
    if (bad_stab != 0) begin failures++; $display("[TB] FAIL bp_stability got %0d violations expected 0", bad_stab); end
    checks++;
    if (bad_fields + bad_wlast + bad_overlap != 0) begin
      failures++;
      $display("[TB] FAIL bp_protocol got fields=%0d wlast=%0d overlap=%0d expected 0",
               bad_fields, bad_wlast, bad_overlap);
    end
  endtask

  task automatic test_error_response();
    do_reset();
    run_sweep(0, 3, -1, 0, -1, 0);
    checks++;
    if (done_cycle != 41) begin failures++; $display("[TB] FAIL err_done_cycle got %0d expected 41", done_cycle); end
    checks++;
    if ({o_init_done, o_init_error} !== {1'b1, model_err}) begin
      failures++;
      $display("[TB] FAIL err_flags got %b expected %b", {o_init_done, o_init_error}, {1'b1, model_err});
    end
    checks++;
    if (content_errors() != 0) begin
      failures++; $display("[TB] FAIL err_contents got %0d bad words expected 0", content_errors());
    end
    run_sweep(0, -1, -1, 1, -1, 0);
    checks++;
    if (err_after_start !== 1'b0) begin
      failures++; $display("[TB] FAIL err_cleared_by_start got %b expected 0", err_after_start);
    end
    checks++;
    if (done_cycle != 41) begin failures++; $display("[TB] FAIL rerun_done_cycle got %0d expected 41", done_cycle); end
    checks++;
    if (o_init_error !== model_err) begin
      failures++; $display("[TB] FAIL rerun_error got %b expected %b", o_init_error, model_err);
    end
    checks++;
    if (aw_errors() != 0) begin failures++; $display("[TB] FAIL rerun_awaddr got %0d bad expected 0", aw_errors()); end
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    run_sweep(0, -1, 5, 0, -1, 0);
    #1;
    checks++;
    if ({o_awvalid, o_wvalid, o_bready, o_busy, o_init_done, o_init_error, o_wlast} !== 7'b0
        || o_awaddr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs got flags=%b addr=%h expected 0",
               {o_awvalid, o_wvalid, o_bready, o_busy, o_init_done, o_init_error, o_wlast}, o_awaddr);
    end
    run_sweep(0, -1, -1, 0, -1, 0);
    checks++;
    if (aw_log.size() == 0 || aw_log[0] !== 32'h0) begin
      failures++; $display("[TB] FAIL midreset_restart_addr got size=%0d expected first addr 0", aw_log.size());
    end
    checks++;
    if (done_cycle != 41) begin failures++; $display("[TB] FAIL midreset_done_cycle got %0d expected 41", done_cycle); end
    checks++;
    if (content_errors() != 0) begin
      failures++; $display("[TB] FAIL midreset_contents got %0d bad words expected 0", content_errors());
    end
  endtask

  task automatic test_ignored_start();
    int drops;
    do_reset();
    run_sweep(0, -1, -1, 0, 3, 1);
    checks++;
    if (done_cycle != 41) begin failures++; $display("[TB] FAIL ignstart_done_cycle got %0d expected 41", done_cycle); end
    checks++;
    if (aw_errors() != 0) begin failures++; $display("[TB] FAIL ignstart_awaddr got %0d bad expected 0", aw_errors()); end
    drops = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (o_init_done !== 1'b1 || o_awvalid !== 1'b0 || o_busy !== 1'b0) drops++;
    end
    checks++;
    if (drops != 0) begin failures++; $display("[TB] FAIL ignstart_no_restart got %0d bad cycles expected 0", drops); end
  endtask

  initial begin
    test_reset();
    test_default_sweep();
    test_backpressure();
    test_error_response();
    test_reset_mid_sweep();
    test_ignored_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
